// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game widths, playfield border and shot FSM encoding
package game_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;
  localparam int Y_TOP   = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } shot_state_e;

endpackage

// File: rtl/button_edge_sync.sv
// rtl/button_edge_sync.sv - two-flop synchronizer with rising-edge pulse for a raw button
module button_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign btn_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/player_shot_controller.sv
// rtl/player_shot_controller.sv - single player shot: launch, upward flight, cooldown and pixel draw
module player_shot_controller
  import game_pkg::*;
#(
  parameter int               SHOT_W        = 2,
  parameter int               SHOT_H        = 8,
  parameter int               SHOT_VELOCITY = 4,
  parameter int               MOVE_INTERVAL = 200000,
  parameter int               COOLDOWN      = 5000000,
  parameter int               Y_TOP         = game_pkg::Y_TOP,
  parameter logic [RGB_W-1:0] SHOT_COLOR    = 12'hFF0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pause,
  input  logic               fire,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic               shot_hit,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               shot_active,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y,
  output logic               shot_on,
  output logic [RGB_W-1:0]   shot_rgb,
  output logic [7:0]         shots_fired
);

  localparam int MV_W = ($clog2(MOVE_INTERVAL) < 1) ? 1 : $clog2(MOVE_INTERVAL);
  localparam int CD_W = ($clog2(COOLDOWN) < 1) ? 1 : $clog2(COOLDOWN);
  localparam int CW1  = COORD_W + 1;

  localparam logic [MV_W-1:0]    MV_LAST  = MV_W'(MOVE_INTERVAL - 1);
  localparam logic [CD_W-1:0]    CD_LAST  = CD_W'(COOLDOWN - 1);
  localparam logic [CW1-1:0]     MISS_LIM = CW1'(Y_TOP + SHOT_VELOCITY);
  localparam logic [COORD_W-1:0] VEL      = COORD_W'(SHOT_VELOCITY);
  localparam logic [COORD_W-1:0] SH_H     = COORD_W'(SHOT_H);
  localparam logic [CW1-1:0]     SH_W_EXT = CW1'(SHOT_W);
  localparam logic [CW1-1:0]     SH_H_EXT = CW1'(SHOT_H);

  shot_state_e        state_q, state_d;
  logic [MV_W-1:0]    move_cnt_q, move_cnt_d;
  logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
  logic [COORD_W-1:0] shot_x_q, shot_x_d;
  logic [COORD_W-1:0] shot_y_q, shot_y_d;
  logic [7:0]         shots_fired_q, shots_fired_d;
  logic               shot_on_q, shot_on_d;
  logic [RGB_W-1:0]   shot_rgb_q, shot_rgb_d;
  logic               fire_req;

  button_edge_sync u_fire_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (fire),
    .btn_rise (fire_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      move_cnt_q    <= '0;
      cd_cnt_q      <= '0;
      shot_x_q      <= '0;
      shot_y_q      <= '0;
      shots_fired_q <= '0;
      shot_on_q     <= 1'b0;
      shot_rgb_q    <= '0;
    end else begin
      state_q       <= state_d;
      move_cnt_q    <= move_cnt_d;
      cd_cnt_q      <= cd_cnt_d;
      shot_x_q      <= shot_x_d;
      shot_y_q      <= shot_y_d;
      shots_fired_q <= shots_fired_d;
      shot_on_q     <= shot_on_d;
      shot_rgb_q    <= shot_rgb_d;
    end
  end

  // Pause freezes everything here; requests seen while paused are simply lost.
  always_comb begin
    state_d       = state_q;
    move_cnt_d    = move_cnt_q;
    cd_cnt_d      = cd_cnt_q;
    shot_x_d      = shot_x_q;
    shot_y_d      = shot_y_q;
    shots_fired_d = shots_fired_q;
    if (!pause) begin
      case (state_q)
        ST_IDLE: begin
          if (fire_req) begin
            state_d    = ST_FLYING;
            shot_x_d   = player_x;
            shot_y_d   = (player_y < SH_H) ? '0 : player_y - SH_H;
            move_cnt_d = '0;
            if (shots_fired_q != 8'hFF) begin
              shots_fired_d = shots_fired_q + 8'd1;
            end
          end
        end
        ST_FLYING: begin
          if (shot_hit) begin
            state_d  = ST_COOLDOWN;
            cd_cnt_d = '0;
          end else if (move_cnt_q == MV_LAST) begin
            move_cnt_d = '0;
            if ({1'b0, shot_y_q} < MISS_LIM) begin
              state_d  = ST_COOLDOWN;
              cd_cnt_d = '0;
            end else begin
              shot_y_d = shot_y_q - VEL;
            end
          end else begin
            move_cnt_d = move_cnt_q + MV_W'(1);
          end
        end
        ST_COOLDOWN: begin
          if (cd_cnt_q == CD_LAST) begin
            state_d  = ST_IDLE;
            cd_cnt_d = '0;
          end else begin
            cd_cnt_d = cd_cnt_q + CD_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bounds are widened by one bit so a shot near the right/bottom edge cannot wrap.
  always_comb begin
    shot_active = (state_q == ST_FLYING);
    shot_on_d   = shot_active
                  && ({1'b0, pixel_x} >= {1'b0, shot_x_q})
                  && ({1'b0, pixel_x} <  ({1'b0, shot_x_q} + SH_W_EXT))
                  && ({1'b0, pixel_y} >= {1'b0, shot_y_q})
                  && ({1'b0, pixel_y} <  ({1'b0, shot_y_q} + SH_H_EXT));
    shot_rgb_d  = shot_on_d ? SHOT_COLOR : '0;
  end

  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;
  assign shot_on     = shot_on_q;
  assign shot_rgb    = shot_rgb_q;
  assign shots_fired = shots_fired_q;

endmodule
